// File: rtl/msx_ram_arbiter.sv
// Shares the SDRAM controller port between CPU slot accesses and the flash programming engine.
// Fixed CPU priority with a starvation limit for flash, plus a WAIT-state watchdog.
module msx_ram_arbiter #(
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_rnw,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait,
  input  logic              flash_req,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [7:0]        flash_din,
  output logic              flash_ready,
  output logic              flash_done,
  output logic              sd_req,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  input  logic              sd_ready,
  input  logic              sd_done,
  input  logic [7:0]        sd_dout,
  output logic              err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WD_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ISSUE,
    CPU_WAIT,
    FL_ISSUE,
    FL_WAIT
  } state_t;

  state_t              state, state_n;
  logic [STARVE_W-1:0] starve, starve_n;
  logic [WD_W-1:0]     wd, wd_n;

  logic              sd_req_n;
  logic [ADDR_W-1:0] sd_addr_n;
  logic [7:0]        sd_din_n;
  logic              sd_we_n;
  logic [7:0]        cpu_dout_n;
  logic              cpu_ack_n;
  logic              flash_ready_n;
  logic              flash_done_n;
  logic              err_n;

  logic fl_pri;
  logic cpu_pri;
  logic starved;
  logic wd_expired;

  assign starved    = (starve == STARVE_W'(STARVE_LIMIT));
  assign fl_pri     = flash_req & (~cpu_req | starved);
  assign cpu_pri    = cpu_req & ~fl_pri;
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
  assign cpu_wait   = cpu_req & ~cpu_ack;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      starve      <= '0;
      wd          <= '0;
      sd_req      <= 1'b0;
      sd_addr     <= '0;
      sd_din      <= '0;
      sd_we       <= 1'b0;
      cpu_dout    <= 8'hFF;
      cpu_ack     <= 1'b0;
      flash_ready <= 1'b0;
      flash_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      starve      <= starve_n;
      wd          <= wd_n;
      sd_req      <= sd_req_n;
      sd_addr     <= sd_addr_n;
      sd_din      <= sd_din_n;
      sd_we       <= sd_we_n;
      cpu_dout    <= cpu_dout_n;
      cpu_ack     <= cpu_ack_n;
      flash_ready <= flash_ready_n;
      flash_done  <= flash_done_n;
      err         <= err_n;
    end
  end

  // Arbitration, handshake sequencing and watchdog
  always_comb begin
    state_n       = state;
    starve_n      = starve;
    wd_n          = wd;
    sd_req_n      = sd_req;
    sd_addr_n     = sd_addr;
    sd_din_n      = sd_din;
    sd_we_n       = sd_we;
    cpu_dout_n    = cpu_dout;
    cpu_ack_n     = 1'b0;
    flash_ready_n = 1'b0;
    flash_done_n  = 1'b0;
    err_n         = 1'b0;

    case (state)
      IDLE: begin
        if (fl_pri) begin
          sd_addr_n     = flash_addr;
          sd_din_n      = flash_din;
          sd_we_n       = 1'b1;
          sd_req_n      = 1'b1;
          flash_ready_n = 1'b1;
          starve_n      = '0;
          state_n       = FL_ISSUE;
        end else if (cpu_pri) begin
          sd_addr_n = cpu_addr;
          sd_din_n  = cpu_din;
          sd_we_n   = ~cpu_rnw;
          sd_req_n  = 1'b1;
          if (flash_req && !starved) begin
            starve_n = starve + STARVE_W'(1);
          end
          state_n = CPU_ISSUE;
        end
      end

      CPU_ISSUE: begin
        if (sd_ready) begin
          sd_req_n = 1'b0;
          state_n  = CPU_WAIT;
        end
      end

      FL_ISSUE: begin
        if (sd_ready) begin
          sd_req_n = 1'b0;
          state_n  = FL_WAIT;
        end
      end

      CPU_WAIT: begin
        if (sd_done) begin
          cpu_ack_n = 1'b1;
          if (!sd_we) begin
            cpu_dout_n = sd_dout;
          end
          state_n = IDLE;
        end else if (wd_expired) begin
          // Lost completion: release the CPU with open-bus data
          err_n      = 1'b1;
          cpu_ack_n  = 1'b1;
          cpu_dout_n = 8'hFF;
          state_n    = IDLE;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end

      FL_WAIT: begin
        if (sd_done) begin
          flash_done_n = 1'b1;
          state_n      = IDLE;
        end else if (wd_expired) begin
          err_n        = 1'b1;
          flash_done_n = 1'b1;
          state_n      = IDLE;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end

      default: begin
        sd_req_n = 1'b0;
        state_n  = IDLE;
      end
    endcase

    if (state_n != state) begin
      wd_n = '0;
    end
  end

endmodule

// File: tb/tb_msx_ram_arbiter.sv
// Randomized self-checking bench for msx_ram_arbiter; a transaction-level model tracks
// expected SDRAM traffic, read data, arbitration order and watchdog timing.
module tb_msx_ram_arbiter;

  localparam int unsigned AW    = 27;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned TMO   = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_rnw;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          cpu_wait;
  logic          flash_req;
  logic [AW-1:0] flash_addr;
  logic [7:0]    flash_din;
  logic          flash_ready;
  logic          flash_done;
  logic          sd_req;
  logic [AW-1:0] sd_addr;
  logic [7:0]    sd_din;
  logic          sd_we;
  logic          sd_ready;
  logic          sd_done;
  logic [7:0]    sd_dout;
  logic          err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_dout;

  msx_ram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rnw(cpu_rnw),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .flash_req(flash_req), .flash_addr(flash_addr), .flash_din(flash_din),
    .flash_ready(flash_ready), .flash_done(flash_done),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we),
    .sd_ready(sd_ready), .sd_done(sd_done), .sd_dout(sd_dout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access; rd = cycles before sd_ready, dd = WAIT cycles before sd_done
  task automatic cpu_txn(input logic [AW-1:0] a, input logic [7:0] d, input logic rnw,
                         input int rd, input int dd, input logic [7:0] rdata, input bit lost);
    bit early;
    cpu_addr = a; cpu_din = d; cpu_rnw = rnw; cpu_req = 1'b1;
    @(negedge clk);
    check("cpu_sd_req", 32'(sd_req), 32'd1);
    check("cpu_sd_addr", 32'(sd_addr), 32'(a));
    check("cpu_sd_din", 32'(sd_din), 32'(d));
    check("cpu_sd_we", 32'(sd_we), 32'(rnw ? 1'b0 : 1'b1));
    check("cpu_wait_hi", 32'(cpu_wait), 32'd1);
    cpu_addr = AW'($urandom); cpu_din = 8'($urandom); cpu_rnw = 1'($urandom);
    early = 1'b0;
    for (int i = 0; i < rd; i++) begin
      sd_ready = 1'b0;
      @(negedge clk);
      if (sd_req !== 1'b1) early = 1'b1;
    end
    check("cpu_issue_hold", 32'(early), 32'd0);
    sd_ready = 1'b1;
    @(negedge clk);
    sd_ready = 1'b0;
    check("cpu_sd_req_drop", 32'(sd_req), 32'd0);
    check("cpu_addr_frozen", 32'(sd_addr), 32'(a));
    early = 1'b0;
    if (lost) begin
      for (int k = 1; k <= int'(TMO); k++) begin
        if (err !== 1'b0 || cpu_ack !== 1'b0) early = 1'b1;
        @(negedge clk);
      end
      exp_dout = 8'hFF;
      check("cpu_wd_early", 32'(early), 32'd0);
      check("cpu_wd_err", 32'(err), 32'd1);
      check("cpu_wd_ack", 32'(cpu_ack), 32'd1);
      check("cpu_wd_dout", 32'(cpu_dout), 32'(exp_dout));
    end else begin
      for (int i = 0; i < dd; i++) begin
        @(negedge clk);
        if (cpu_ack !== 1'b0) early = 1'b1;
      end
      sd_done = 1'b1; sd_dout = rdata;
      @(negedge clk);
      sd_done = 1'b0; sd_dout = 8'($urandom);
      if (rnw) exp_dout = rdata;
      check("cpu_early_ack", 32'(early), 32'd0);
      check("cpu_ack", 32'(cpu_ack), 32'd1);
      check("cpu_dout", 32'(cpu_dout), 32'(exp_dout));
      check("cpu_wait_lo", 32'(cpu_wait), 32'd0);
      check("cpu_err", 32'(err), 32'd0);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    check("cpu_ack_pulse", 32'(cpu_ack), 32'd0);
    check("cpu_idle_req", 32'(sd_req), 32'd0);
  endtask

  // One flash write, same handshake shaping as cpu_txn
  task automatic flash_txn(input logic [AW-1:0] a, input logic [7:0] d,
                           input int rd, input int dd, input bit lost);
    bit early;
    flash_addr = a; flash_din = d; flash_req = 1'b1;
    @(negedge clk);
    check("fl_ready", 32'(flash_ready), 32'd1);
    check("fl_sd_req", 32'(sd_req), 32'd1);
    check("fl_sd_addr", 32'(sd_addr), 32'(a));
    check("fl_sd_din", 32'(sd_din), 32'(d));
    check("fl_sd_we", 32'(sd_we), 32'd1);
    flash_addr = AW'($urandom); flash_din = 8'($urandom);
    early = 1'b0;
    for (int i = 0; i < rd; i++) begin
      sd_ready = 1'b0;
      @(negedge clk);
      if (sd_req !== 1'b1 || flash_ready !== 1'b0) early = 1'b1;
    end
    check("fl_issue_hold", 32'(early), 32'd0);
    sd_ready = 1'b1;
    @(negedge clk);
    sd_ready = 1'b0;
    check("fl_sd_req_drop", 32'(sd_req), 32'd0);
    check("fl_ready_pulse", 32'(flash_ready), 32'd0);
    check("fl_din_frozen", 32'(sd_din), 32'(d));
    early = 1'b0;
    if (lost) begin
      for (int k = 1; k <= int'(TMO); k++) begin
        if (err !== 1'b0 || flash_done !== 1'b0) early = 1'b1;
        @(negedge clk);
      end
      check("fl_wd_early", 32'(early), 32'd0);
      check("fl_wd_err", 32'(err), 32'd1);
      check("fl_wd_done", 32'(flash_done), 32'd1);
    end else begin
      for (int i = 0; i < dd; i++) begin
        @(negedge clk);
        if (flash_done !== 1'b0) early = 1'b1;
      end
      sd_done = 1'b1; sd_dout = 8'($urandom);
      @(negedge clk);
      sd_done = 1'b0;
      check("fl_early_done", 32'(early), 32'd0);
      check("fl_done", 32'(flash_done), 32'd1);
      check("fl_err", 32'(err), 32'd0);
      check("fl_cpu_dout_kept", 32'(cpu_dout), 32'(exp_dout));
    end
    flash_req = 1'b0;
    @(negedge clk);
    check("fl_done_pulse", 32'(flash_done), 32'd0);
  endtask

  // Continuous CPU reads against a held flash request; SDRAM answers immediately
  task automatic contention();
    int  order[$];
    bit  acc;
    bit  prev_req;
    int  first_fl;
    acc = 1'b0; prev_req = 1'b0;
    sd_dout = 8'h5A;
    cpu_rnw = 1'b1; cpu_addr = AW'($urandom); cpu_req = 1'b1;
    flash_addr = AW'($urandom); flash_din = 8'($urandom); flash_req = 1'b1;
    for (int cyc = 0; cyc < 300 && order.size() < int'(LIMIT) + 2; cyc++) begin
      @(negedge clk);
      if (sd_req && !prev_req) order.push_back(sd_we ? 1 : 0);
      if (flash_done) flash_req = 1'b0;
      sd_done = acc; acc = sd_req; sd_ready = sd_req; prev_req = sd_req;
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cpu_ack) cpu_req = 1'b0;
      if (flash_done) flash_req = 1'b0;
      sd_done = acc; acc = sd_req; sd_ready = sd_req;
    end
    sd_ready = 1'b0; sd_done = 1'b0; cpu_req = 1'b0; flash_req = 1'b0;
    exp_dout = 8'h5A;
    first_fl = -1;
    foreach (order[i]) if (order[i] == 1 && first_fl < 0) first_fl = i;
    check("arb_grants", 32'(order.size()), 32'(LIMIT + 2));
    check("arb_first_cpu", 32'(order[0]), 32'd0);
    check("arb_cpu_before_fl", 32'(first_fl), 32'(LIMIT));
    check("arb_cpu_resumes", 32'(order[LIMIT + 1]), 32'd0);
    check("arb_idle", 32'(sd_req), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_rnw = 1'b1;
    flash_req = 1'b0; flash_addr = '0; flash_din = '0;
    sd_ready = 1'b0; sd_done = 1'b0; sd_dout = '0;
    exp_dout = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_sd_req", 32'(sd_req), 32'd0);
    check("rst_sd_we", 32'(sd_we), 32'd0);
    check("rst_sd_addr", 32'(sd_addr), 32'd0);
    check("rst_sd_din", 32'(sd_din), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("rst_flags", 32'({cpu_ack, flash_ready, flash_done, err, cpu_wait}), 32'd0);
    reset = 1'b0;
    // Stale completion while idle after reset
    sd_done = 1'b1;
    @(negedge clk);
    sd_done = 1'b0;
    check("stale_done_rst", 32'({cpu_ack, flash_done, sd_req}), 32'd0);

    cpu_txn(AW'(32'h0004000), 8'h00, 1'b1, 0, 3, 8'hA5, 1'b0);
    flash_txn(AW'(32'h0100000), 8'h3C, 2, 2, 1'b0);
    contention();
    contention();

    cpu_txn(AW'($urandom), 8'($urandom), 1'b1, 1, 0, 8'h77, 1'b1);
    sd_done = 1'b1;
    @(negedge clk);
    sd_done = 1'b0;
    @(negedge clk);
    check("stale_done_wd", 32'({cpu_ack, flash_done, err, sd_req}), 32'd0);
    flash_txn(AW'($urandom), 8'($urandom), 0, 0, 1'b1);

    // Reset in CPU_WAIT, then a late completion
    cpu_addr = AW'($urandom); cpu_rnw = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    sd_ready = 1'b1;
    @(negedge clk);
    sd_ready = 1'b0; reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_dout = 8'hFF;
    check("midrst_sd_req", 32'(sd_req), 32'd0);
    check("midrst_regs", 32'({sd_we, sd_din, sd_addr}), 32'd0);
    check("midrst_dout", 32'(cpu_dout), 32'hFF);
    sd_done = 1'b1; sd_dout = 8'h11;
    @(negedge clk);
    sd_done = 1'b0;
    check("midrst_no_ack", 32'({cpu_ack, flash_done, err}), 32'd0);
    check("midrst_dout_kept", 32'(cpu_dout), 32'hFF);
    cpu_txn(AW'($urandom), 8'($urandom), 1'b1, 0, 1, 8'h3E, 1'b0);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0)
        flash_txn(AW'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), 1'b0);
      else
        cpu_txn(AW'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msx_ram_arbiter.md
Name: msx_ram_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: CPU slot accesses (RAM/ROM/mapper traffic) and the flash programming engine.
- Sits between the slot subsystem and the SDRAM controller.
- Sequences each access through a request/accept/done handshake, latches address and data per transaction, and returns read data.
- Fixed CPU priority with a starvation limit guarantees flash progress; a watchdog recovers from a lost completion.

Parameters:
ADDR_W, 27, SDRAM byte address width
STARVE_LIMIT, 8, consecutive CPU grants while flash is pending before flash is forced to win
TIMEOUT, 255, max cycles in a WAIT state before abort (8-bit counter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_addr  in  ADDR_W  CPU address
cpu_din  in  8  CPU write data
cpu_rnw  in  1  1 = read, 0 = write
cpu_dout  out  8  read data; valid when cpu_ack = 1
cpu_ack  out  1  one-cycle completion pulse
cpu_wait  out  1  stall to CPU; equals cpu_req & ~cpu_ack
flash_req  in  1  flash write request; held high until flash_done
flash_addr  in  ADDR_W  flash target address
flash_din  in  8  flash write data
flash_ready  out  1  one-cycle pulse on flash grant
flash_done  out  1  one-cycle pulse on flash completion
sd_req  out  1  request to SDRAM controller
sd_addr  out  ADDR_W  latched address
sd_din  out  8  latched write data
sd_we  out  1  1 = write
sd_ready  in  1  controller accepts sd_req in this cycle
sd_done  in  1  access complete; sd_dout valid
sd_dout  in  8  read data
err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- All outputs registered except cpu_wait.
- Reset values: sd_req = 0, sd_we = 0, sd_addr = 0, sd_din = 0, cpu_dout = FF, cpu_ack = 0, flash_ready = 0, flash_done = 0, err = 0, state = IDLE, starve = 0, watchdog = 0.
- States: IDLE, CPU_ISSUE, CPU_WAIT, FL_ISSUE, FL_WAIT.
- IDLE arbitration (flash priority and cpu priority below are mutually exclusive):
  - Flash priority = flash_req & (~cpu_req | starve == STARVE_LIMIT).
  - CPU priority = cpu_req & ~flash priority.
  - CPU grant: latch cpu_addr/cpu_din, sd_we = ~cpu_rnw, go to CPU_ISSUE. If flash_req is also high, starve increments, saturating at STARVE_LIMIT.
  - Flash grant: latch flash_addr/flash_din, sd_we = 1, pulse flash_ready, clear starve, go to FL_ISSUE.
- ISSUE states:
  - sd_req = 1 until a cycle with sd_ready = 1, then sd_req = 0 and go to the matching WAIT state.
  - sd_req is high for at least one cycle.
- CPU_WAIT, on sd_done:
  - If ~sd_we, cpu_dout <= sd_dout; otherwise cpu_dout holds its last value.
  - cpu_ack pulses for 1 cycle, then IDLE.
- FL_WAIT, on sd_done: flash_done pulses, then IDLE.
- Back-to-back: a requester still high in the cycle after its ack is a new request (ack cycle is spent returning to IDLE). Requesters must drop req in the ack/done cycle to avoid a duplicate access.
- Latency: cpu_req rises at IDLE cycle N -> sd_req at N+1. With sd_ready at N+1 and sd_done at cycle M, cpu_ack and cpu_dout appear at M+1. Minimum is 3 cycles from request to ack.
- Watchdog:
  - Counts cycles in both WAIT states; cleared on every state change.
  - On reaching TIMEOUT: err pulses; CPU path pulses cpu_ack with cpu_dout = FF; flash path pulses flash_done. Then IDLE.
- sd_done outside WAIT states (stale, or after reset) is ignored.
- Reset mid-transaction: sd_req drops the next cycle, state returns to IDLE, latched transaction is discarded, no ack/done is issued.
- Address and data are frozen from grant until completion; requester inputs may change freely afterward.

Test Plan:
1. CPU read: cpu_req = 1, cpu_addr = 0x0004000, rnw = 1; sd_ready = 1 immediately; sd_done 4 cycles later with sd_dout = A5 -> sd_req high exactly 1 cycle, sd_we = 0, cpu_ack 1 cycle later with cpu_dout = A5; cpu_wait falls in the ack cycle.
2. Flash write alone: flash_req, addr = 0x0100000, din = 3C; sd_ready delayed 3 cycles -> flash_ready pulse, sd_req held 3 cycles, sd_we = 1, sd_din = 3C, flash_done after sd_done.
3. Contention: CPU requests continuously, flash_req held -> exactly 8 CPU grants, then the flash grant, starve reset to 0, then CPU resumes.
4. Simultaneous cpu_req and flash_req with starve = 0 -> CPU served first, starve = 1.
5. Timeout: CPU read, sd_done never arrives -> after 255 WAIT cycles, err pulse, cpu_ack with cpu_dout = FF, state IDLE; a subsequent late sd_done is ignored.
6. Reset asserted during CPU_WAIT, then sd_done -> no cpu_ack, all outputs at reset values, next request served normally.
